ps2_kbd_decoder: RTL and testbench

PS/2 keyboard front end. It samples the raw PS/2 clock/data lines, assembles and checks 11-bit frames, and buffers scancodes in a small FIFO. A parser strips break (F0) and extended (E0) prefixes, then drives the scancode as the read address of the downstream scancode-to-ASCII lookup RAM. It captures the ASCII that RAM returns and presents one key event per valid/ready handshake to the console/CPU side.

---
 rtl/ps2_kbd_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_ps2_kbd_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: PS/2 keyboard front end -> scancode FIFO -> prefix parser -> ASCII lookup -> key events.
// Latency: FIFO pop of a non-prefix byte to key_valid high is 3 clk; PS/2 edge detect adds 3 clk of sync.
// Backpressure: key_valid is held with key_* stable until key_ready; frames keep landing in the FIFO
//   meanwhile; a frame arriving with the FIFO full (and no pop that cycle) is dropped and sets overflow.
//
// Ports:
//   clk, clrn            system clock, asynchronous active-low reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 lines
//   lut_addr / lut_data  read address to / ASCII from the scancode lookup RAM (1 clk read latency)
//   key_valid/key_ready  event handshake; key_code, key_ascii, key_make carry the event
//   key_down, press_cnt  hold tracking: a key is held / number of distinct presses
//   frame_err, overflow  sticky error flags, cleared only by reset

// Small generic first-word-fall-through FIFO.
// Latency: a pushed word is visible on o_dat the cycle after the push.
// Backpressure: a push into a full FIFO is accepted only if a pop happens in the same cycle; else o_drop.
module ps2_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop     = i_pop && !o_empty;
  // When full, the popped slot is the one being written, and the read happens before the edge.
  assign w_push_ok = i_push && (!w_full || w_pop);
  assign o_drop    = i_push && !w_push_ok;
  assign o_dat     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module ps2_kbd_decoder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] lut_addr,
  input  logic [7:0] lut_data,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_make,
  output logic       key_down,
  output logic [7:0] press_cnt,
  output logic       frame_err,
  output logic       overflow
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchronisers. Sync flops reset to 0 so a PS/2 clock that is already
  // low when reset is released cannot be mistaken for a falling edge.
  // ---------------------------------------------------------------------------
  logic [2:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       w_fall;
  logic       w_bit;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end

  // r_clk_sync[1] and r_dat_sync[1] are the same age, so the data bit lines up with the edge.
  assign w_fall = r_clk_sync[2] && !r_clk_sync[1];
  assign w_bit  = r_dat_sync[1];

  // ---------------------------------------------------------------------------
  // Frame assembly. Bits arrive LSB first and shift in at the top, so after 10
  // edges r_shift = {parity, data[7:0], start}; the 11th bit (stop) is w_bit.
  // ---------------------------------------------------------------------------
  logic [9:0]    r_shift;
  logic [3:0]    r_bit_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          w_frame_done;
  logic          w_frame_good;
  logic          w_frame_vld;
  logic          w_frame_bad;
  logic [7:0]    w_frame_dat;

  assign w_frame_done = w_fall && (r_bit_cnt == 4'd10);
  // Odd parity across data and parity bit means the XOR of all nine is 1.
  assign w_frame_good = !r_shift[0] && w_bit && (^r_shift[9:1]);
  assign w_frame_vld  = w_frame_done && w_frame_good;
  assign w_frame_bad  = w_frame_done && !w_frame_good;
  assign w_frame_dat  = r_shift[8:1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
      if (r_bit_cnt == 4'd10) begin
        r_bit_cnt <= '0;
      end else begin
        r_shift   <= {w_bit, r_shift[9:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end else if (r_bit_cnt != 4'd0) begin
      // A stalled partial frame is abandoned quietly; it is not a framing error.
      if (r_to_cnt == TW'(TIMEOUT)) begin
        r_bit_cnt <= '0;
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scancode FIFO
  // ---------------------------------------------------------------------------
  logic [7:0] w_fifo_dat;
  logic       w_fifo_empty;
  logic       w_fifo_drop;
  logic       w_pop;

  ps2_kbd_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (clrn),
    .i_push  (w_frame_vld),
    .i_dat   (w_frame_dat),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_dat),
    .o_empty (w_fifo_empty),
    .o_drop  (w_fifo_drop)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (w_frame_bad) begin
        frame_err <= 1'b1;
      end
      if (w_fifo_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Parser FSM: state register / next state / control strobes
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_is_prefix;
  logic   w_load;
  logic   w_set_brk;
  logic   w_cap;
  logic   w_ack;

  assign w_is_prefix = (w_fifo_dat == BRK_CODE) || (w_fifo_dat == EXT_CODE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty && !w_is_prefix) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:  w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_OUT;
      S_OUT: begin
        if (key_valid && key_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_set_brk = 1'b0;
    w_cap     = 1'b0;
    w_ack     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop     = !w_fifo_empty;
        w_load    = !w_fifo_empty && !w_is_prefix;
        w_set_brk = !w_fifo_empty && (w_fifo_dat == BRK_CODE);
      end
      S_CAP:   w_cap = 1'b1;
      S_OUT:   w_ack = key_valid && key_ready;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event datapath and hold tracking. key_code doubles as the byte being
  // processed; it is loaded together with lut_addr and is stable through CAP.
  // ---------------------------------------------------------------------------
  logic       r_brk;
  logic [7:0] r_held_code;
  logic       w_same_key;

  assign w_same_key = (key_code == r_held_code);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lut_addr    <= '0;
      key_code    <= '0;
      key_ascii   <= '0;
      key_make    <= 1'b0;
      key_valid   <= 1'b0;
      key_down    <= 1'b0;
      press_cnt   <= '0;
      r_brk       <= 1'b0;
      r_held_code <= '0;
    end else begin
      if (w_load) begin
        lut_addr <= w_fifo_dat;
        key_code <= w_fifo_dat;
      end
      // E0 leaves a pending break flag alone, so F0 E0 xx still reports a release.
      if (w_set_brk) begin
        r_brk <= 1'b1;
      end
      if (w_cap) begin
        key_ascii <= lut_data;
        key_make  <= !r_brk;
        key_valid <= 1'b1;
        r_brk     <= 1'b0;
        if (!r_brk) begin
          // Auto-repeat of the key already held does not count as a new press.
          if (!key_down || !w_same_key) begin
            press_cnt <= press_cnt + 1'b1;
          end
          key_down    <= 1'b1;
          r_held_code <= key_code;
        end else if (w_same_key) begin
          key_down <= 1'b0;
        end
      end
      if (w_ack) begin
        key_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb_ps2_kbd_decoder: directed PS/2 frame sequences against ps2_kbd_decoder with a synchronous lookup RAM model.
// Latency: events are collected by a handshake monitor and checked after each directed step.
// Backpressure: key_ready is held low during the overflow step and high elsewhere.
module tb_ps2_kbd_decoder;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] lut_addr;
  logic [7:0] lut_data;
  logic       key_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] key_ascii;
  logic       key_make;
  logic       key_down;
  logic [7:0] press_cnt;
  logic       frame_err;
  logic       overflow;

  int errs   = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       make;
    logic       down;
    logic [7:0] cnt;
  } ev_t;

  ev_t evq[$];

  ps2_kbd_decoder #(.DEPTH(8), .TIMEOUT(5000)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ascii (key_ascii),
    .key_make  (key_make),
    .key_down  (key_down),
    .press_cnt (press_cnt),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lut_fn(input logic [7:0] a);
    return (a == 8'h1C) ? 8'h61 : (a + 8'h20);
  endfunction

  // Synchronous lookup RAM: data valid one clk after the address is sampled.
  always @(posedge clk) lut_data <= lut_fn(lut_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] prev_addr;
  logic       prev_vld;
  int         addr_cyc = 0;
  int         vld_cyc  = 0;

  always @(negedge clk) begin
    prev_addr <= lut_addr;
    prev_vld  <= key_valid;
    if (lut_addr !== prev_addr) addr_cyc <= cyc;
    if (key_valid === 1'b1 && prev_vld === 1'b0) vld_cyc <= cyc;
    if (clrn && key_valid && key_ready)
      evq.push_back('{code: key_code, ascii: key_ascii, make: key_make, down: key_down, cnt: press_cnt});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] d, input logic bad);
    return {1'b1, (~^d) ^ bad, d, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    wait_clk(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    ps2_bits(mkframe(d, 1'b0), 11);
  endtask

  function automatic ev_t take();
    ev_t e;
    e = 'x;
    if (evq.size() > 0) e = evq.pop_front();
    return e;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_addr"},  lut_addr,  0);
    chk({tag, "_code"},  key_code,  0);
    chk({tag, "_ascii"}, key_ascii, 0);
    chk({tag, "_make"},  key_make,  0);
    chk({tag, "_down"},  key_down,  0);
    chk({tag, "_cnt"},   press_cnt, 0);
    chk({tag, "_ferr"},  frame_err, 0);
    chk({tag, "_ovf"},   overflow,  0);
  endtask

  logic [7:0] codes [10];
  ev_t        ev;

  initial begin
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    clrn      = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    key_ready = 1'b1;
    wait_clk(5);
    chk_idle_outputs("rst");
    clrn = 1'b1;
    wait_clk(5);

    // Make A
    send(8'h1C);
    wait_clk(40);
    chk("makeA_nev", evq.size(), 1);
    ev = take();
    chk("makeA_code",  ev.code,  8'h1C);
    chk("makeA_ascii", ev.ascii, 8'h61);
    chk("makeA_make",  ev.make,  1);
    chk("makeA_down",  ev.down,  1);
    chk("makeA_cnt",   ev.cnt,   1);
    chk("makeA_addr",  lut_addr, 8'h1C);
    chk("makeA_addr_to_valid", vld_cyc - addr_cyc, 2);

    // Auto-repeat then release
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    wait_clk(40);
    chk("rep_nev", evq.size(), 4);
    for (int i = 0; i < 3; i++) begin
      ev = take();
      chk("rep_code", ev.code, 8'h1C);
      chk("rep_make", ev.make, 1);
      chk("rep_cnt",  ev.cnt,  1);
    end
    ev = take();
    chk("brk_code",  ev.code,  8'h1C);
    chk("brk_ascii", ev.ascii, 8'h61);
    chk("brk_make",  ev.make,  0);
    chk("brk_down",  ev.down,  0);
    chk("brk_cnt",   ev.cnt,   1);

    // Extended release: E0 F0 75
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    wait_clk(40);
    chk("ext_nev", evq.size(), 1);
    ev = take();
    chk("ext_code",  ev.code,  8'h75);
    chk("ext_ascii", ev.ascii, 8'h95);
    chk("ext_make",  ev.make,  0);
    chk("ext_down",  ev.down,  0);
    chk("ext_cnt",   ev.cnt,   1);

    // Partial frame abandoned by timeout
    ps2_bits(mkframe(8'h2D, 1'b0), 5);
    wait_clk(5100);
    send(8'h1C);
    wait_clk(40);
    chk("to_nev", evq.size(), 1);
    ev = take();
    chk("to_code", ev.code, 8'h1C);
    chk("to_make", ev.make, 1);
    chk("to_down", ev.down, 1);
    chk("to_cnt",  ev.cnt,  2);
    chk("to_ferr", frame_err, 0);

    // Bad parity
    ps2_bits(mkframe(8'h1C, 1'b1), 11);
    wait_clk(40);
    chk("par_ferr",  frame_err, 1);
    chk("par_valid", key_valid, 0);
    chk("par_nev",   evq.size(), 0);
    chk("par_ovf",   overflow, 0);

    // Backpressure and overflow
    key_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(codes[i]);
    wait_clk(40);
    chk("ovf_before", overflow, 0);
    send(codes[9]);
    wait_clk(40);
    chk("ovf_set",       overflow,  1);
    chk("ovf_valid",     key_valid, 1);
    chk("ovf_held_code", key_code,  8'h15);
    chk("ovf_held_asc",  key_ascii, 8'h35);
    chk("ovf_held_cnt",  press_cnt, 3);
    chk("ovf_nev",       evq.size(), 0);
    key_ready = 1'b1;
    wait_clk(200);
    chk("drain_nev", evq.size(), 9);
    for (int i = 0; i < 9; i++) begin
      ev = take();
      chk("drain_code",  ev.code,  codes[i]);
      chk("drain_ascii", ev.ascii, codes[i] + 8'h20);
      chk("drain_make",  ev.make,  1);
      chk("drain_down",  ev.down,  1);
      chk("drain_cnt",   ev.cnt,   3 + i);
    end
    chk("drain_valid", key_valid, 0);

    // Reset in the middle of a frame, with the PS/2 clock low
    ps2_bits(mkframe(8'h2D, 1'b0), 5);
    ps2_data = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(3);
    clrn = 1'b0;
    wait_clk(10);
    chk_idle_outputs("midrst");
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(10);
    clrn = 1'b1;
    wait_clk(10);
    send(8'h1C);
    wait_clk(40);
    chk("post_nev", evq.size(), 1);
    ev = take();
    chk("post_code",  ev.code,  8'h1C);
    chk("post_ascii", ev.ascii, 8'h61);
    chk("post_make",  ev.make,  1);
    chk("post_down",  ev.down,  1);
    chk("post_cnt",   ev.cnt,   1);
    chk("post_ferr",  frame_err, 0);
    chk("post_ovf",   overflow,  0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
